// File: rtl/sequenciador_servo_if.sv
// sequenciador_servo_if
//   Command channel between the robot's move controller and the servo
//   sequencer.
//   master (move controller): drives iniciar, alvo, cancelar;
//                             receives pronto, ocupado, fim, erro.
//   slave  (sequencer)      : the opposite directions.
//   iniciar  : command valid, accepted on a rising edge while pronto=1
//   alvo     : target position 0..2 (3 is illegal)
//   cancelar : abort the move in progress
//   pronto   : ready to accept a command
//   ocupado  : a move is in progress (dwell running)
//   fim      : one-cycle pulse when a move completes
//   erro     : one-cycle pulse when an illegal target is rejected
interface sequenciador_servo_if;
  logic       iniciar;
  logic [1:0] alvo;
  logic       cancelar;
  logic       pronto;
  logic       ocupado;
  logic       fim;
  logic       erro;

  modport master (
    output iniciar, alvo, cancelar,
    input  pronto, ocupado, fim, erro
  );

  modport slave (
    input  iniciar, alvo, cancelar,
    output pronto, ocupado, fim, erro
  );
endinterface

// File: rtl/sequenciador_servo.sv
// sequenciador_servo
//   Upstream command stage for circuito_pwm_3. Takes a target servo position
//   (0/1/2) over a valid/ready handshake and walks the PWM width select one
//   position per step, dwelling conf_periodo*ciclos_espera clocks after each
//   step so the servo can finish travelling, then pulses fim.
//
//   Parameters
//     conf_periodo        clocks per PWM period (must match the PWM block)
//     ciclos_espera       PWM periods to dwell after each step
//     passo_intermediario 1: a 0<->2 move passes through 1; 0: jump directly
//     The product conf_periodo*ciclos_espera must be at least 1.
//
//   Ports
//     clock    system clock
//     reset    asynchronous, active-low reset
//     cmd      command channel (slave side), see sequenciador_servo_if
//     largura  2-bit position select to circuito_pwm_3
module sequenciador_servo #(
  parameter int unsigned conf_periodo        = 1250,
  parameter int unsigned ciclos_espera       = 25,
  parameter int unsigned passo_intermediario = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  sequenciador_servo_if.slave  cmd,
  output logic [1:0]           largura
);

  localparam logic [31:0] N_ESPERA = 32'(conf_periodo * ciclos_espera);
  localparam logic [31:0] ULTIMO   = N_ESPERA - 32'd1;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    FIM    = 2'd2
  } estado_t;

  estado_t     estado_q,   estado_d;
  logic [1:0]  largura_q,  largura_d;
  logic [1:0]  alvo_reg_q, alvo_reg_d;
  logic [31:0] cont_q,     cont_d;
  logic        fim_q,      fim_d;
  logic        erro_q,     erro_d;

  // Next position on the way from 'atual' to 'destino'. With the
  // intermediate step enabled, a two-position jump lands on 1 first.
  function automatic logic [1:0] proximo_passo(input logic [1:0] destino,
                                               input logic [1:0] atual);
    logic salto_duplo;
    salto_duplo = ((destino == 2'd2) && (atual == 2'd0)) ||
                  ((destino == 2'd0) && (atual == 2'd2));
    if ((passo_intermediario != 0) && salto_duplo)
      return 2'd1;
    else
      return destino;
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      largura_q  <= '0;
      alvo_reg_q <= '0;
      cont_q     <= '0;
      fim_q      <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      largura_q  <= largura_d;
      alvo_reg_q <= alvo_reg_d;
      cont_q     <= cont_d;
      fim_q      <= fim_d;
      erro_q     <= erro_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    estado_d   = estado_q;
    largura_d  = largura_q;
    alvo_reg_d = alvo_reg_q;
    cont_d     = cont_q;
    erro_d     = 1'b0;

    unique case (estado_q)
      OCIOSO: begin
        if (cmd.iniciar) begin
          if (cmd.alvo == 2'd3) begin
            // Illegal target: flag it and stay ready, nothing else moves.
            erro_d = 1'b1;
          end else if (cmd.alvo == largura_q) begin
            estado_d = FIM;
          end else begin
            alvo_reg_d = cmd.alvo;
            largura_d  = proximo_passo(cmd.alvo, largura_q);
            cont_d     = '0;
            estado_d   = ESPERA;
          end
        end
      end

      ESPERA: begin
        // Abort wins over the end-of-dwell decision on the same edge.
        if (cmd.cancelar) begin
          estado_d = OCIOSO;
          cont_d   = '0;
        end else if (cont_q == ULTIMO) begin
          cont_d = '0;
          if (largura_q == alvo_reg_q)
            estado_d = FIM;
          else
            largura_d = proximo_passo(alvo_reg_q, largura_q);
        end else begin
          cont_d = cont_q + 32'd1;
        end
      end

      FIM: begin
        estado_d = OCIOSO;
      end

      default: begin
        estado_d = OCIOSO;
        cont_d   = '0;
      end
    endcase

    // fim is registered: it is high exactly for the cycle spent in FIM.
    fim_d = (estado_d == FIM);
  end

  // Outputs
  always_comb begin
    cmd.pronto  = (estado_q == OCIOSO);
    cmd.ocupado = (estado_q == ESPERA);
    cmd.fim     = fim_q;
    cmd.erro    = erro_q;
    largura     = largura_q;
  end

endmodule

// File: tb/tb_sequenciador_servo.sv
// tb_sequenciador_servo
//   Drives two sequencers (intermediate step on / off) with the same command
//   stream. Expected fim/erro events are queued when a command is issued and
//   popped by a monitor whenever a DUT pulses fim or erro.
module tb_sequenciador_servo;
  localparam int unsigned PER = 10;
  localparam int unsigned ESP = 2;
  localparam int          N   = PER * ESP;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iniciar, cancelar;
  logic [1:0] alvo;

  sequenciador_servo_if bus0();
  sequenciador_servo_if bus1();
  logic [1:0] larg0, larg1;

  assign bus0.iniciar  = iniciar;
  assign bus0.alvo     = alvo;
  assign bus0.cancelar = cancelar;
  assign bus1.iniciar  = iniciar;
  assign bus1.alvo     = alvo;
  assign bus1.cancelar = cancelar;

  sequenciador_servo #(
    .conf_periodo(PER), .ciclos_espera(ESP), .passo_intermediario(0)
  ) dut0 (.clock(clk), .reset(rst_n), .cmd(bus0), .largura(larg0));

  sequenciador_servo #(
    .conf_periodo(PER), .ciclos_espera(ESP), .passo_intermediario(1)
  ) dut1 (.clock(clk), .reset(rst_n), .cmd(bus1), .largura(larg1));

  logic       pr [2], oc [2], fi [2], er [2];
  logic [1:0] lg [2];
  assign pr[0] = bus0.pronto;  assign pr[1] = bus1.pronto;
  assign oc[0] = bus0.ocupado; assign oc[1] = bus1.ocupado;
  assign fi[0] = bus0.fim;     assign fi[1] = bus1.fim;
  assign er[0] = bus0.erro;    assign er[1] = bus1.erro;
  assign lg[0] = larg0;        assign lg[1] = larg1;

  typedef struct {
    bit         is_erro;
    int         quando;
    logic [1:0] pos;
    int         occ;
  } ev_t;

  ev_t        sb [2][$];
  logic [1:0] pos_m [2];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every fim/erro pulse.
  int occ_cnt  [2] = '{0, 0};
  bit fim_prev [2] = '{0, 0};
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ev_t e;
      if (fim_prev[d]) chk("pronto_after_fim", d, int'(pr[d]), 1);
      if (fi[d] && er[d]) chk("fim_and_erro", d, 1, 0);
      if (fi[d] || er[d]) begin
        if (sb[d].size() == 0) begin
          chk("unexpected_event", d, 1, 0);
        end else begin
          e = sb[d].pop_front();
          chk("event_kind", d, int'(er[d]), int'(e.is_erro));
          chk("event_cycle", d, cyc, e.quando);
          chk("event_largura", d, int'(lg[d]), int'(e.pos));
          if (e.is_erro) chk("pronto_on_erro", d, int'(pr[d]), 1);
          else           chk("ocupado_cycles", d, occ_cnt[d], e.occ);
        end
      end
      if (pr[d])      occ_cnt[d] = 0;
      else if (oc[d]) occ_cnt[d]++;
      fim_prev[d] = fi[d];
    end
  end

  task automatic chk_idle(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_pronto"},  d, int'(pr[d]), 1);
      chk({nm, "_ocupado"}, d, int'(oc[d]), 0);
      chk({nm, "_fim"},     d, int'(fi[d]), 0);
      chk({nm, "_erro"},    d, int'(er[d]), 0);
      chk({nm, "_largura"}, d, int'(lg[d]), 0);
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!(pr[0] && pr[1]) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("ready_timeout", 0, 0, 1);
  endtask

  // Issue one command; k>0 pulses cancelar at accept edge + k; inj tries a
  // busy-time command (alvo=2) three edges after accept.
  task automatic send(input logic [1:0] a, input int k, input bit inj);
    int         e0;
    bit         inj_ok;
    logic [1:0] first [2];
    wait_ready();
    for (int d = 0; d < 2; d++) chk("largura_idle", d, int'(lg[d]), int'(pos_m[d]));
    e0     = cyc + 1;
    inj_ok = inj && (k == 0);
    for (int d = 0; d < 2; d++) begin
      logic [1:0] p;
      logic [1:0] path [2];
      int         s;
      ev_t        e;
      p = pos_m[d];
      first[d] = p;
      if (a == 2'd3) begin
        e = '{1'b1, e0, p, 0};
        sb[d].push_back(e);
        inj_ok = 1'b0;
      end else if (a == p) begin
        e = '{1'b0, e0, p, 0};
        sb[d].push_back(e);
        inj_ok = 1'b0;
      end else begin
        if (d == 1 && ((a == 2'd2 && p == 2'd0) || (a == 2'd0 && p == 2'd2))) begin
          path[0] = 2'd1; path[1] = a; s = 2;
        end else begin
          path[0] = a; path[1] = a; s = 1;
        end
        first[d] = path[0];
        if (k > 0 && k <= s * N) begin
          pos_m[d] = path[(k - 1) / N];
        end else begin
          pos_m[d] = a;
          e = '{1'b0, e0 + s * N, a, s * N};
          sb[d].push_back(e);
        end
      end
    end
    iniciar = 1'b1;
    alvo    = a;
    @(negedge clk);
    iniciar = 1'b0;
    alvo    = 2'($urandom);
    for (int d = 0; d < 2; d++) chk("largura_at_accept", d, int'(lg[d]), int'(first[d]));
    if (k > 0) begin
      while (cyc < e0 + k - 1) @(negedge clk);
      cancelar = 1'b1;
      @(negedge clk);
      cancelar = 1'b0;
    end
    if (inj_ok) begin
      repeat (2) @(negedge clk);
      iniciar = 1'b1;
      alvo    = 2'd2;
      @(negedge clk);
      iniciar = 1'b0;
    end
  endtask

  initial begin
    iniciar  = 1'b0;
    alvo     = 2'd0;
    cancelar = 1'b0;
    rst_n    = 1'b0;
    pos_m[0] = 2'd0;
    pos_m[1] = 2'd0;
    repeat (2) @(negedge clk);
    chk_idle("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset_release");

    // Directed cases
    send(2'd1, 0, 1'b1);      // single step, busy command ignored
    send(2'd1, 0, 1'b0);      // already there: immediate fim
    send(2'd3, 0, 1'b0);      // illegal target
    send(2'd0, 0, 1'b0);
    send(2'd2, 0, 1'b0);      // 0->2: two steps vs direct
    send(2'd0, N, 1'b0);      // cancel at terminal count
    send(2'd0, 0, 1'b0);
    send(2'd2, 2 * N, 1'b0);  // cancel on the last edge of a two-step move
    send(2'd2, 0, 1'b0);

    // Random commands
    for (int i = 0; i < 40; i++) begin
      logic [1:0] a;
      int         k;
      a = 2'($urandom_range(0, 3));
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * N + 2)) : 0;
      send(a, k, ($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset in the middle of a dwell
    send(2'd0, 0, 1'b0);
    send(2'd2, 0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    for (int d = 0; d < 2; d++) begin
      sb[d].delete();
      pos_m[d] = 2'd0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd1, 0, 1'b0);
    wait_ready();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("scoreboard_empty", d, sb[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
